// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory controller and its SRAM.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - MMIO register offsets within the MMIO window
//   - request record latched on acceptance
//   - width helper for the latency down-counter
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] MMIO_TOHOST = 8'h00;
  localparam logic [7:0] MMIO_CYCLES = 8'h04;
  localparam logic [7:0] MMIO_PUTC   = 8'h08;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

  // For reads, data holds the MMIO read value sampled at acceptance.
  typedef struct packed {
    req_kind_e   kind;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // The counter is loaded with (latency - 2), so it only needs to hold
  // values up to max latency - 2; never narrower than one bit.
  function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH_WORDS x 32 single-port data array.
//   clk    in   clock, rising edge
//   we     in   write enable (synchronous write)
//   re     in   read enable; rdata updates only when re is high
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
// No reset: contents survive a controller reset and may be preloaded
// from a bench through the mem array.
module dmem_sram #(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the core load/store port.
// Word-addressed SRAM with configurable read/write wait states plus a
// small MMIO window (TOHOST finish register, cycle counter, console byte).
//   clk, rst       clock / async active-high reset
//   i_addr         byte address; bit MMIO_BIT selects the MMIO window
//   i_wdata        store data
//   i_wen, i_ren   store / load request (both high = store, flags o_err)
//   o_rdata        load data, valid with o_read_vd, held otherwise
//   o_read_vd      one-cycle load-data-valid pulse
//   o_stall        core stall; request is held by the core while high
//   o_done         sticky, set by TOHOST write with data[0] = 1
//   o_exit_code    TOHOST data[31:1] captured with o_done
//   o_putc_valid   one-cycle console strobe, o_putc_data = byte
//   o_cycles       free-running cycle counter
//   o_err          sticky protocol error
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 8192,
  parameter int ADDR_W      = 13,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1,
  parameter int MMIO_BIT    = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wen,
  input  logic        i_ren,
  output logic [31:0] o_rdata,
  output logic        o_read_vd,
  output logic        o_stall,
  output logic        o_done,
  output logic [30:0] o_exit_code,
  output logic        o_putc_valid,
  output logic [7:0]  o_putc_data,
  output logic [31:0] o_cycles,
  output logic        o_err
);

  localparam int CW = lat_cnt_w(RD_LAT, WR_LAT);

  localparam logic [1:0] RSEL_NONE = 2'd0;
  localparam logic [1:0] RSEL_SRAM = 2'd1;
  localparam logic [1:0] RSEL_MMIO = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  req_t          req_q;
  logic [1:0]    rsel_q;
  logic [31:0]   mmio_rdata_q;
  logic [31:0]   sram_rdata;
  logic [31:0]   cycle_q;

  logic          accept;
  logic          fast_wr;
  logic          to_resp;
  logic          wr_commit;
  logic          rd_enter;
  int            lat_sel;
  logic [31:0]   rd_val_now;
  logic          cur_write;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_data;
  logic          cur_mmio;
  logic [7:0]    cur_off;
  logic          unused_addr;

  assign accept  = (state == ST_IDLE) && (i_wen || i_ren);
  assign fast_wr = accept && i_wen && (WR_LAT == 0);
  assign lat_sel = i_wen ? WR_LAT : RD_LAT;

  // CYCLES must return the count at the acceptance cycle, so the MMIO
  // read value is sampled here and carried in the request record.
  assign rd_val_now = (i_addr[MMIO_BIT] && (i_addr[7:0] == MMIO_CYCLES)) ? cycle_q : '0;

  // The "current" request is the live input in IDLE (single-cycle paths)
  // and the latched record once the FSM has left IDLE.
  always_comb begin
    cur_write = 1'b0;
    cur_addr  = '0;
    cur_data  = '0;
    if (state == ST_IDLE) begin
      cur_write = i_wen;
      cur_addr  = i_addr;
      cur_data  = i_wen ? i_wdata : rd_val_now;
    end else begin
      cur_write = (req_q.kind == REQ_WRITE);
      cur_addr  = req_q.addr;
      cur_data  = req_q.data;
    end
  end

  assign cur_mmio    = cur_addr[MMIO_BIT];
  assign cur_off     = cur_addr[7:0];
  assign unused_addr = ^cur_addr;

  // to_resp marks the edge that enters RESP: writes commit and reads
  // capture their data on that edge.
  always_comb begin
    to_resp = 1'b0;
    if (state == ST_IDLE) to_resp = accept && !fast_wr && (lat_sel == 1);
    else if (state == ST_WAIT) to_resp = (wait_cnt == '0);
  end

  assign wr_commit = fast_wr || (to_resp && cur_write);
  assign rd_enter  = to_resp && !cur_write;

  assign o_stall   = (accept && !fast_wr) || (state == ST_WAIT);
  assign o_read_vd = (state == ST_RESP) && (req_q.kind == REQ_READ);
  assign o_cycles  = cycle_q;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_sram (
    .clk  (clk),
    .we   (wr_commit && !cur_mmio),
    .re   (rd_enter && !cur_mmio),
    .addr (cur_addr[ADDR_W+1:2]),
    .wdata(cur_data),
    .rdata(sram_rdata)
  );

  // Request FSM. WAIT lasts latency-1 cycles; latency 1 skips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !fast_wr) begin
            req_q.kind <= i_wen ? REQ_WRITE : REQ_READ;
            req_q.addr <= i_addr;
            req_q.data <= i_wen ? i_wdata : rd_val_now;
            if (lat_sel == 1) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CW'(lat_sel - 2);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_RESP;
          else wait_cnt <= wait_cnt - CW'(1);
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-data source select: o_rdata only changes when a read enters RESP,
  // so it holds its last value between loads and reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel_q       <= RSEL_NONE;
      mmio_rdata_q <= '0;
    end else if (rd_enter) begin
      rsel_q <= cur_mmio ? RSEL_MMIO : RSEL_SRAM;
      if (cur_mmio) mmio_rdata_q <= cur_data;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (rsel_q == RSEL_SRAM) o_rdata = sram_rdata;
    else if (rsel_q == RSEL_MMIO) o_rdata = mmio_rdata_q;
  end

  // Cycle counter, sticky status and MMIO write side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q      <= '0;
      o_done       <= 1'b0;
      o_exit_code  <= '0;
      o_putc_valid <= 1'b0;
      o_putc_data  <= '0;
      o_err        <= 1'b0;
    end else begin
      cycle_q      <= cycle_q + 32'd1;
      o_putc_valid <= 1'b0;
      if (accept && i_wen && i_ren) o_err <= 1'b1;
      if (wr_commit && cur_mmio) begin
        if ((cur_off == MMIO_TOHOST) && cur_data[0] && !o_done) begin
          o_done      <= 1'b1;
          o_exit_code <= cur_data[31:1];
        end
        if (cur_off == MMIO_PUTC) begin
          o_putc_valid <= 1'b1;
          o_putc_data  <= cur_data[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Three instances share the
// request inputs: d_ (default latencies), z_ (WR_LAT = 0) and
// w_ (WR_LAT = 2, so writes pass through WAIT). Each step checks only the
// instance it targets; idle gaps resynchronise the others.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;

  logic [31:0] d_rdata, z_rdata, w_rdata;
  logic        d_read_vd, z_read_vd, w_read_vd;
  logic        d_stall, z_stall, w_stall;
  logic        d_done, z_done, w_done;
  logic [30:0] d_exit, z_exit, w_exit;
  logic        d_putc_valid, z_putc_valid, w_putc_valid;
  logic [7:0]  d_putc_data, z_putc_data, w_putc_data;
  logic [31:0] d_cycles, z_cycles, w_cycles;
  logic        d_err, z_err, w_err;

  logic        unused_outs;

  int checks   = 0;
  int failures = 0;

  assign unused_outs = ^{d_exit, d_putc_data, z_read_vd, z_done, z_exit, z_putc_data,
                         z_cycles, z_err, w_putc_valid, w_done};

  dmem_ctrl u_dut_d (
    .clk(clk), .rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wen(wen), .i_ren(ren),
    .o_rdata(d_rdata), .o_read_vd(d_read_vd), .o_stall(d_stall), .o_done(d_done),
    .o_exit_code(d_exit), .o_putc_valid(d_putc_valid), .o_putc_data(d_putc_data),
    .o_cycles(d_cycles), .o_err(d_err)
  );

  dmem_ctrl #(.WR_LAT(0)) u_dut_z (
    .clk(clk), .rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wen(wen), .i_ren(ren),
    .o_rdata(z_rdata), .o_read_vd(z_read_vd), .o_stall(z_stall), .o_done(z_done),
    .o_exit_code(z_exit), .o_putc_valid(z_putc_valid), .o_putc_data(z_putc_data),
    .o_cycles(z_cycles), .o_err(z_err)
  );

  dmem_ctrl #(.WR_LAT(2)) u_dut_w (
    .clk(clk), .rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wen(wen), .i_ren(ren),
    .o_rdata(w_rdata), .o_read_vd(w_read_vd), .o_stall(w_stall), .o_done(w_done),
    .o_exit_code(w_exit), .o_putc_valid(w_putc_valid), .o_putc_data(w_putc_data),
    .o_cycles(w_cycles), .o_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle per call: drive at the falling edge, settle, then checks follow.
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    wen   = w;
    ren   = r;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst   = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    addr  = '0;
    wdata = '0;

    // Reset state
    idle(2);
    checkOutput("rst_stall",   32'(d_stall),      32'd0);
    checkOutput("rst_read_vd", 32'(d_read_vd),    32'd0);
    checkOutput("rst_rdata",   d_rdata,           32'd0);
    checkOutput("rst_done",    32'(d_done),       32'd0);
    checkOutput("rst_putc",    32'(d_putc_valid), 32'd0);
    checkOutput("rst_cycles",  d_cycles,          32'd0);
    checkOutput("rst_err",     32'(d_err),        32'd0);

    // CYCLES read accepted at cycle 20 after reset release
    @(negedge clk);
    rst = 1'b0;
    idle(19);
    applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h0);
    checkOutput("cyc_count_at_accept", d_cycles, 32'd20);
    checkOutput("cyc_stall_t0", 32'(d_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0004, 32'h0);
    checkOutput("cyc_stall_t1", 32'(d_stall), 32'd1);
    checkOutput("cyc_vd_t1", 32'(d_read_vd), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("cyc_stall_resp", 32'(d_stall), 32'd0);
    checkOutput("cyc_vd_resp", 32'(d_read_vd), 32'd1);
    checkOutput("cyc_rdata", d_rdata, 32'd20);
    checkOutput("cyc_rdata_wr0", z_rdata, 32'd20);
    idle(3);

    // Default latencies: write then read 0x40
    applyStimulus(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    checkOutput("wr_stall_t0", 32'(d_stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr_stall_resp", 32'(d_stall), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h0);
    checkOutput("rd_stall_t0", 32'(d_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h0);
    checkOutput("rd_stall_t1", 32'(d_stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rd_vd", 32'(d_read_vd), 32'd1);
    checkOutput("rd_stall_resp", 32'(d_stall), 32'd0);
    checkOutput("rd_data", d_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rd_vd_drop", 32'(d_read_vd), 32'd0);
    checkOutput("rd_data_hold", d_rdata, 32'hDEAD_BEEF);
    idle(3);

    // WR_LAT = 0: back-to-back writes without stall, then read both
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h11);
    checkOutput("wr0_stall_a", 32'(z_stall), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h22);
    checkOutput("wr0_stall_b", 32'(z_stall), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    checkOutput("wr0_rd_stall", 32'(z_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr0_rd_a", z_rdata, 32'h11);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h4, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr0_rd_b", z_rdata, 32'h22);
    idle(3);

    // MMIO: PUTC, then TOHOST finish and a later ignored TOHOST write
    applyStimulus(1'b1, 1'b0, 32'h8000_0008, 32'h55);
    checkOutput("putc_stall", 32'(d_stall), 32'd1);
    checkOutput("putc_early", 32'(d_putc_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("putc_valid", 32'(d_putc_valid), 32'd1);
    checkOutput("putc_data", 32'(d_putc_data), 32'h55);
    checkOutput("putc_valid_wr0", 32'(z_putc_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("putc_pulse_end", 32'(d_putc_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h7);
    checkOutput("tohost_done_early", 32'(d_done), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("tohost_done", 32'(d_done), 32'd1);
    checkOutput("tohost_exit", 32'(d_exit), 32'd3);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h9);
    idle(2);
    checkOutput("tohost_sticky_done", 32'(d_done), 32'd1);
    checkOutput("tohost_sticky_exit", 32'(d_exit), 32'd3);
    idle(2);

    // Simultaneous load/store: treated as store, sticky error
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hA5);
    checkOutput("both_stall", 32'(d_stall), 32'd1);
    checkOutput("both_err_early", 32'(d_err), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("both_err", 32'(d_err), 32'd1);
    checkOutput("both_no_vd", 32'(d_read_vd), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("both_rd_vd", 32'(d_read_vd), 32'd1);
    checkOutput("both_rd_data", d_rdata, 32'hA5);
    checkOutput("both_err_sticky", 32'(d_err), 32'd1);
    idle(3);

    // WR_LAT = 2: seed 0x80, then reset in WAIT of a second write
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h1234_5678);
    checkOutput("w2_stall_t0", 32'(w_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'h1234_5678);
    checkOutput("w2_stall_t1", 32'(w_stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("w2_stall_resp", 32'(w_stall), 32'd0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 32'h80, 32'hCAFE_F00D);
    checkOutput("w2_in_wait", 32'(w_stall), 32'd1);
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    #1;
    checkOutput("w2rst_stall",   32'(w_stall),      32'd0);
    checkOutput("w2rst_read_vd", 32'(w_read_vd),    32'd0);
    checkOutput("w2rst_rdata",   w_rdata,           32'd0);
    checkOutput("w2rst_exit",    32'(w_exit),       32'd0);
    checkOutput("w2rst_putc",    32'(w_putc_data),  32'd0);
    checkOutput("w2rst_cycles",  w_cycles,          32'd0);
    checkOutput("w2rst_err",     32'(w_err),        32'd0);
    idle(1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h0);
    checkOutput("w2_rd_stall", 32'(w_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h80, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("w2_rd_vd", 32'(w_read_vd), 32'd1);
    checkOutput("w2_rd_prior", w_rdata, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller on the core's load/store port; replaces the bench's ideal zero-wait array.
- Provides word-addressed SRAM with configurable read/write wait states, driving the core's stall and read-valid inputs.
- Decodes a small MMIO window: TOHOST finish register, cycle counter, console byte port. Lets benches end a run from software instead of a fixed timeout.

Parameters:
- DEPTH_WORDS, 8192, SRAM depth in 32-bit words; power of two.
- ADDR_W, 13, word-index width; equals log2(DEPTH_WORDS).
- RD_LAT, 2, read latency in cycles; must be >= 1.
- WR_LAT, 1, write wait states; 0 means the write commits with no stall.
- MMIO_BIT, 31, address bit that selects the MMIO window.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_addr  in  32  byte address from core (o_memaddr)
- i_wdata  in  32  store data
- i_wen  in  1  store request
- i_ren  in  1  load request
- o_rdata  out  32  load data, valid while o_read_vd is high
- o_read_vd  out  1  load data valid, one-cycle pulse
- o_stall  out  1  to core i_exstall; core holds its request while this is high
- o_done  out  1  sticky, set by a TOHOST write with data bit 0 = 1
- o_exit_code  out  31  TOHOST data [31:1], captured with o_done
- o_putc_valid  out  1  console byte strobe, one cycle
- o_putc_data  out  8  console byte
- o_cycles  out  32  free-running cycle counter
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (async, any state): FSM to IDLE; pending request dropped; all outputs 0; o_cycles = 0. SRAM contents are not cleared.
- Address decode:
  - i_addr[MMIO_BIT] = 0 selects SRAM at index i_addr[ADDR_W+1:2]. Other upper bits and [1:0] are ignored; access is word-only.
  - MMIO offsets (i_addr[7:0]): 0x00 TOHOST (write-only, reads 0), 0x04 CYCLES (read-only, writes ignored), 0x08 PUTC (write-only). Unmapped offsets read 0 and ignore writes.
- FSM states:
  - IDLE. A request is accepted when i_wen or i_ren is high. On accept, latch addr, wdata and type, and load the wait counter.
  - WAIT. Counter decrements each cycle.
  - RESP. One cycle, then back to IDLE. Inputs are ignored in RESP.
- Read, accepted at cycle t:
  - o_stall high combinationally at t and registered through t+RD_LAT-1.
  - At t+RD_LAT (RESP): o_stall = 0, o_read_vd = 1, o_rdata = word captured on entry to RESP.
  - The next request can be accepted at t+RD_LAT+1.
- Write with WR_LAT = 0: commits at the edge ending cycle t; no stall; FSM stays in IDLE.
- Write with WR_LAT > 0:
  - o_stall high for t..t+WR_LAT-1.
  - Commits at the edge entering RESP.
  - RESP at t+WR_LAT with o_stall = 0.
- i_wen and i_ren both high: treated as a write; o_err set, sticky until reset.
- MMIO access uses the same latency as the SRAM access of the same type.
- TOHOST commit:
  - data[0] = 1: o_done set to 1 and o_exit_code = data[31:1]. Later TOHOST writes are ignored once o_done is set.
  - data[0] = 0: no effect.
- PUTC commit: o_putc_valid high for exactly one cycle, the cycle after the commit edge; o_putc_data = data[7:0].
- o_cycles increments every cycle after reset, wraps 0xFFFFFFFF -> 0. A CYCLES read returns the value at the acceptance cycle t.
- o_rdata holds its last value outside o_read_vd.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state encoding (IDLE, WAIT, RESP)
  - MMIO offset constants (TOHOST = 0x00, CYCLES = 0x04, PUTC = 0x08)
  - latency-counter width function
- Sub-module dmem_sram: DEPTH_WORDS x 32 array, synchronous write, registered read. It has no reset and supports $readmemh preload.

Test Plan:
- Default params; write 0xDEADBEEF to 0x40, then read 0x40:
  - write: o_stall high for 1 cycle
  - read: o_stall high for 2 cycles, then o_read_vd = 1 with o_rdata = 0xDEADBEEF.
- WR_LAT = 0; write 0x11 to 0x0 and 0x22 to 0x4 back-to-back, then read both -> no stall on the writes; reads return 0x11 and 0x22.
- Write 0x55 to 0x8000_0008 -> one o_putc_valid pulse with o_putc_data = 0x55. Write 0x0000_0007 to 0x8000_0000 -> o_done = 1, o_exit_code = 3. A later write of 0x9 leaves o_exit_code = 3.
- Read 0x8000_0004 accepted at cycle 20 after reset release -> o_rdata = 20 on o_read_vd.
- Assert rst during WAIT of a write to 0x80 -> all outputs 0 and FSM in IDLE; a subsequent read of 0x80 returns its prior content.
- i_wen = i_ren = 1 at 0x10 with data 0xA5 -> write of 0xA5 performed, o_err = 1 and stays set; a later read of 0x10 returns 0xA5.
